// File: rtl/tx_packet.sv
// tx_packet: serialises an 8-byte framed packet over a UART-style line
// (8N1, LSB first, no inter-byte gap).
// Packet: STX, {0,addr}, tx_data bytes LSB first, byte6, ETX.
// Optional macro TX_CHECKSUM_EN: when defined, byte6 is the XOR of bytes 1..5.
// Otherwise byte6 is 8'h00.
module tx_packet #(
  parameter int unsigned BIT_CYCLES = 2604,
  parameter logic [7:0]  STX        = 8'h02,
  parameter logic [7:0]  ETX        = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [6:0]  addr,
  input  logic [31:0] tx_data,
  output logic        data_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStartBit,
    StDataBits,
    StStopBit,
    StDone
  } state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_baud_cnt, w_baud_next;
  logic [2:0]      r_bit_cnt, w_bit_next;
  logic [2:0]      r_byte_cnt, w_byte_next;
  logic [6:0]      r_addr, w_addr_next;
  logic [31:0]     r_data, w_data_next;

  logic            w_bit_end;
  logic            w_accept;
  logic [7:0]      w_byte6;
  logic [7:0]      w_cur_byte;

  assign w_bit_end = (r_baud_cnt == BaudLast);
  // Requests are only taken when the line is free; DONE counts as free.
  assign w_accept  = tx_start && ((r_state == StIdle) || (r_state == StDone));

  // Select the byte currently on the wire from the latched request.
  always_comb begin
    w_byte6 = 8'h00;
`ifdef TX_CHECKSUM_EN
    w_byte6 = {1'b0, r_addr} ^ r_data[7:0] ^ r_data[15:8] ^ r_data[23:16] ^ r_data[31:24];
`endif
    w_cur_byte = STX;
    unique case (r_byte_cnt)
      3'd0: w_cur_byte = STX;
      3'd1: w_cur_byte = {1'b0, r_addr};
      3'd2: w_cur_byte = r_data[7:0];
      3'd3: w_cur_byte = r_data[15:8];
      3'd4: w_cur_byte = r_data[23:16];
      3'd5: w_cur_byte = r_data[31:24];
      3'd6: w_cur_byte = w_byte6;
      3'd7: w_cur_byte = ETX;
      default: w_cur_byte = STX;
    endcase
  end

  // State, counter and request registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      r_byte_cnt <= w_byte_next;
      r_addr     <= w_addr_next;
      r_data     <= w_data_next;
    end
  end

  // Next-state logic: baud counter wraps each bit, bit/byte counters step on wrap.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud_cnt;
    w_bit_next   = r_bit_cnt;
    w_byte_next  = r_byte_cnt;
    w_addr_next  = r_addr;
    w_data_next  = r_data;

    unique case (r_state)
      StIdle, StDone: begin
        w_state_next = StIdle;
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_byte_next  = '0;
        if (w_accept) begin
          w_state_next = StStartBit;
          w_addr_next  = addr;
          w_data_next  = tx_data;
        end
      end
      StStartBit: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = StDataBits;
        end else begin
          w_baud_next = r_baud_cnt + CntW'(1);
        end
      end
      StDataBits: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = StStopBit;
          end else begin
            w_bit_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_next = r_baud_cnt + CntW'(1);
        end
      end
      StStopBit: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          w_bit_next  = '0;
          if (r_byte_cnt == 3'd7) begin
            w_state_next = StDone;
          end else begin
            w_byte_next  = r_byte_cnt + 3'd1;
            w_state_next = StStartBit;
          end
        end else begin
          w_baud_next = r_baud_cnt + CntW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decode straight from the state register so reset takes effect at once.
  always_comb begin
    data_out = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      StStartBit: begin
        data_out = 1'b0;
        busy     = 1'b1;
      end
      StDataBits: begin
        data_out = w_cur_byte[r_bit_cnt];
        busy     = 1'b1;
      end
      StStopBit: begin
        busy = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        data_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_packet.sv
// Bench for tx_packet with BIT_CYCLES=4: a waveform-queue model predicts the
// line every cycle, and literal decoded packets pin the model.
module tb_tx_packet;

  localparam int BC = 4;
  localparam logic [2:0] IdleT = 3'b100;  // {data_out, busy, done}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_start = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] tx_data = '0;
  logic        data_out, busy, done;

  int n_vec = 0;
  int n_err = 0;

  tx_packet #(.BIT_CYCLES(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .addr     (addr),
    .tx_data  (tx_data),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] q[$];
  logic [2:0] cur = IdleT;

  function automatic logic [7:0] pkt_byte(input int k, input logic [6:0] a, input logic [31:0] d);
    logic [7:0] b [8];
    b[0] = 8'h02;
    b[1] = {1'b0, a};
    b[2] = d[7:0];
    b[3] = d[15:8];
    b[4] = d[23:16];
    b[5] = d[31:24];
`ifdef TX_CHECKSUM_EN
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
`else
    b[6] = 8'h00;
`endif
    b[7] = 8'h03;
    return b[k];
  endfunction

  task automatic push_packet(input logic [6:0] a, input logic [31:0] d);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      v = pkt_byte(k, a, d);
      for (int c = 0; c < BC; c++) q.push_back(3'b010);
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < BC; c++) q.push_back({v[j], 2'b10});
      for (int c = 0; c < BC; c++) q.push_back(3'b110);
    end
    q.push_back(3'b101);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      if (tx_start && !cur[1]) push_packet(addr, tx_data);
      if (q.size() > 0) cur = q.pop_front();
      else cur = IdleT;
    end
  end

  always @(negedge rst) begin
    q.delete();
    cur = IdleT;
  end

  always @(negedge clk) chk("line{do,busy,done}", {29'd0, data_out, busy, done}, {29'd0, cur});

  // ---------------- stimulus helpers ----------------
  logic       rec_do   [0:399];
  logic       rec_busy [0:399];
  logic       rec_done [0:399];
  logic [7:0] exp_b    [8];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [6:0] a, input logic [31:0] d);
    addr = a;
    tx_data = d;
    tx_start = 1'b1;
    cyc();
    tx_start = 1'b0;
  endtask

  task automatic record(input int from, input int to);
    for (int i = from; i < to; i++) begin
      rec_do[i]   = data_out;
      rec_busy[i] = busy;
      rec_done[i] = done;
      cyc();
    end
  endtask

  // Decode the recorded line by mid-bit sampling and compare to exp_b.
  task automatic check_packet(input string nm);
    logic [7:0] v;
    int nb;
    int nd;
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("%s start%0d", nm, b), {31'd0, rec_do[b*10*BC + BC/2]}, 32'd0);
      for (int j = 0; j < 8; j++) v[j] = rec_do[(b*10 + 1 + j)*BC + BC/2];
      chk($sformatf("%s byte%0d", nm, b), {24'd0, v}, {24'd0, exp_b[b]});
      chk($sformatf("%s stop%0d", nm, b), {31'd0, rec_do[(b*10 + 9)*BC + BC/2]}, 32'd1);
    end
    nb = 0;
    nd = 0;
    for (int i = 0; i < 80*BC; i++) begin
      nb += int'(rec_busy[i]);
      nd += int'(rec_done[i]);
    end
    chk({nm, " busy cycles"}, nb, 80*BC);
    chk({nm, " early done"}, nd, 0);
    chk({nm, " done pulse"}, {31'd0, rec_done[80*BC]}, 32'd1);
    chk({nm, " busy end"}, {31'd0, rec_busy[80*BC]}, 32'd0);
  endtask

  initial begin
    // Reset, then 100 idle cycles.
    repeat (3) cyc();
    chk("reset data_out", {31'd0, data_out}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    repeat (100) cyc();
    chk("idle data_out", {31'd0, data_out}, 32'd1);

    // Basic packet.
`ifdef TX_CHECKSUM_EN
    exp_b = '{8'h02, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h27, 8'h03};
`else
    exp_b = '{8'h02, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h03};
`endif
    send(7'h05, 32'hDEADBEEF);
    record(0, 80*BC + 1);
    check_packet("pkt1");
    repeat (5) cyc();

    // tx_start with new data during byte 2 must be ignored.
    send(7'h05, 32'hDEADBEEF);
    record(0, 22*BC + 2);
    addr = 7'h11;
    tx_data = 32'h12345678;
    tx_start = 1'b1;
    record(22*BC + 2, 22*BC + 3);
    tx_start = 1'b0;
    record(22*BC + 3, 80*BC + 1);
    check_packet("busy-ignore");
    repeat (30) cyc();

    // Reset during byte 3, tx_start ignored while in reset, then a clean packet.
    send(7'h05, 32'hDEADBEEF);
    repeat (33*BC) cyc();
    rst = 1'b0;
    #1;
    chk("abort data_out", {31'd0, data_out}, 32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    tx_start = 1'b1;
    cyc();
    cyc();
    tx_start = 1'b0;
    rst = 1'b1;
    repeat (20) cyc();
`ifdef TX_CHECKSUM_EN
    exp_b = '{8'h02, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h03};
`else
    exp_b = '{8'h02, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
`endif
    send(7'h7F, 32'h0);
    record(0, 80*BC + 1);
    check_packet("post-abort");
    repeat (5) cyc();

    // Back-to-back: new request in the done cycle.
    send(7'h2A, 32'hCAFE0123);
    repeat (80*BC) cyc();
    chk("b2b done", {31'd0, done}, 32'd1);
    chk("b2b busy in done", {31'd0, busy}, 32'd0);
`ifdef TX_CHECKSUM_EN
    exp_b = '{8'h02, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h27, 8'h03};
`else
    exp_b = '{8'h02, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h03};
`endif
    send(7'h05, 32'hDEADBEEF);
    chk("b2b start bit", {31'd0, data_out}, 32'd0);
    chk("b2b busy", {31'd0, busy}, 32'd1);
    record(0, 80*BC + 1);
    check_packet("b2b");

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tx_start = ($urandom_range(0, 47) == 0);
      addr = 7'($urandom);
      tx_data = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        cyc();
        rst = 1'b1;
      end
      cyc();
    end
    tx_start = 1'b0;
    repeat (400) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
